// File: rtl/bram_arbiter_2p.sv
// bram_arbiter_2p: shares one single-port block RAM between two requesters.
// Round-robin arbitration per cycle. Grants are combinational and drive the
// BRAM port in the same cycle. Read responses are steered back to their
// requester by a {valid, id} pipeline that matches the BRAM read latency.
// Optional feature macro: ARB_CLEAR_EN. When it is defined, every address is
// zeroed after reset, and requests are held off while that clear runs.
module bram_arbiter_2p #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1        // 1 = primitive only, 2 = output register
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    logic              run;         // grants allowed
    logic              clr_active;  // clear sequencer owns the BRAM port
    logic [ADDR_W-1:0] clr_addr;
    logic              ptr_reg;     // preferred port when both request
    logic [RD_LAT-1:0] pv_reg;      // read pipeline: valid per stage
    logic [RD_LAT-1:0] pid_reg;     // read pipeline: requester id per stage

`ifdef ARB_CLEAR_EN
    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic              busy_reg;

    // Clear FSM: walk every address once after reset, then hand over to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
            busy_reg    <= 1'b1;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    // The counter wraps back to 0 on the last address and is
                    // never used again.
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (&clr_cnt_reg) begin
                        state_reg <= ST_RUN;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    assign run        = (state_reg == ST_RUN);
    assign clr_active = (state_reg == ST_CLEAR);
    assign clr_addr   = clr_cnt_reg;
    assign busy       = busy_reg;
`else
    assign run        = 1'b1;
    assign clr_active = 1'b0;
    assign clr_addr   = '0;
    assign busy       = 1'b0;
`endif

    // Round-robin grant: a lone requester always wins; on contention ptr decides.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && run) begin
            if (req0 && (!req1 || !ptr_reg)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // BRAM port mux: the clear sequencer, then the granted requester, then idle zeros.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (!rst) begin
            if (clr_active) begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_addr;
            end else if (gnt0) begin
                mem_en   = 1'b1;
                mem_we   = we0;
                mem_addr = addr0;
                mem_din  = wdata0;
            end else if (gnt1) begin
                mem_en   = 1'b1;
                mem_we   = we1;
                mem_addr = addr1;
                mem_din  = wdata1;
            end
        end
    end

    // Priority pointer: after a grant, the other port gets preference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else if (gnt0) begin
            ptr_reg <= 1'b1;
        end else if (gnt1) begin
            ptr_reg <= 1'b0;
        end
    end

    // Read tag pipeline: one stage per cycle of BRAM latency. Reset drops in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_reg  <= '0;
            pid_reg <= '0;
        end else begin
            for (int i = 1; i < RD_LAT; i++) begin
                pv_reg[i]  <= pv_reg[i-1];
                pid_reg[i] <= pid_reg[i-1];
            end
            pv_reg[0]  <= (gnt0 && !we0) || (gnt1 && !we1);
            pid_reg[0] <= gnt1;
        end
    end

    assign rvalid0 = pv_reg[RD_LAT-1] && !pid_reg[RD_LAT-1];
    assign rvalid1 = pv_reg[RD_LAT-1] &&  pid_reg[RD_LAT-1];
    assign rdata0  = mem_dout;
    assign rdata1  = mem_dout;

endmodule

// File: tb/tb_bram_arbiter_2p.sv
// Testbench for bram_arbiter_2p. Directed stimulus is applied against a
// behavioural 1-cycle write-first BRAM. A scoreboard queue holds the expected
// read responses, and a negedge monitor pops the queue and compares them.
module tb_bram_arbiter_2p;
    localparam int AW = 10;
    localparam int DW = 32;

`ifdef ARB_CLEAR_EN
    localparam logic [31:0] EXP_BUSY = 32'd1;
    localparam logic [31:0] POST_010 = 32'h0000_0000;   // cleared by reset
    localparam logic [31:0] POST_001 = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_BUSY = 32'd0;
    localparam logic [31:0] POST_010 = 32'hA5A5_A5A5;   // survives reset
    localparam logic [31:0] POST_001 = 32'h0000_1001;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    always #5 clk = ~clk;

    bram_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Behavioural single-port BRAM: 1-cycle read, write-first.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] dout_q;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_din;
                dout_q        <= mem_din;
            end else begin
                dout_q <= ram[mem_addr];
            end
        end
    end
    assign mem_dout = dout_q;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest outstanding read.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rvalid0 || rvalid1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rvalid: got rvalid0=%0b rvalid1=%0b expected none",
                         rvalid0, rvalid1);
            end else begin
                e = sbq.pop_front();
                chk("rvalid_port", {30'b0, rvalid1, rvalid0}, e.port ? 32'd2 : 32'd1);
                chk("rdata", e.port ? rdata1 : rdata0, e.data);
                $display("resp port%0d data=0x%08h (exp 0x%08h)", e.port,
                         e.port ? rdata1 : rdata0, e.data);
            end
        end
    end

    // One arbitration cycle: drive both requesters, check grants, and queue the expected read data.
    task automatic cyc(input string nm,
                       input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input bit eg0, input bit eg1, input logic [DW-1:0] ed, input bit resp);
        exp_t e;
        @(posedge clk);
        #1;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #2;
        chk({nm, "_gnt0"}, 32'(gnt0), 32'(eg0));
        chk({nm, "_gnt1"}, 32'(gnt1), 32'(eg1));
        if (resp && ((eg0 && !w0) || (eg1 && !w1))) begin
            e.port = eg1;
            e.data = ed;
            sbq.push_back(e);
        end
        $display("cyc %s req0=%0b req1=%0b gnt0=%0b gnt1=%0b", nm, r0, r1, gnt0, gnt1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc("idle", 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, '0, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_gnt0"},    32'(gnt0),    32'd0);
        chk({tag, "_gnt1"},    32'(gnt1),    32'd0);
        chk({tag, "_rvalid0"}, 32'(rvalid0), 32'd0);
        chk({tag, "_rvalid1"}, 32'(rvalid1), 32'd0);
        chk({tag, "_mem_en"},  32'(mem_en),  32'd0);
        chk({tag, "_mem_we"},  32'(mem_we),  32'd0);
        chk({tag, "_busy"},    32'(busy),    EXP_BUSY);
        $display("reset check %s", tag);
    endtask

    // Called at posedge+1 right after reset release: spans the clear window, if any.
    task automatic wait_clear();
`ifdef ARB_CLEAR_EN
        int bad = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'h010;
        for (int i = 0; i < (1 << AW); i++) begin
            #2;
            if (!busy || gnt0 || gnt1 || !mem_en || !mem_we || mem_din != '0) bad++;
            @(posedge clk);
            #1;
        end
        #2;
        chk("clear_window_violations", 32'(bad), 32'd0);
        chk("clear_done_busy", 32'(busy), 32'd0);
        req0 = 1'b0;
        $display("clear window observed, violations=%0d", bad);
`endif
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst  = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b1; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #3;
        chk_reset("por");
        @(posedge clk);
        #1;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        wait_clear();

        // Single requester: write, then read back the top address.
        cyc("wr3ff", 1, 1, 10'h3FF, 32'hDEADBEEF, 0, 0, '0, '0, 1, 0, '0, 1);
        chk("wr_mem_en",   32'(mem_en),   32'd1);
        chk("wr_mem_we",   32'(mem_we),   32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h3FF);
        chk("wr_mem_din",  mem_din,       32'hDEADBEEF);
        cyc("rd3ff", 1, 0, 10'h3FF, '0, 0, 0, '0, '0, 1, 0, 32'hDEADBEEF, 1);
        chk("rd_mem_we",   32'(mem_we),   32'd0);
        chk("rd_mem_addr", 32'(mem_addr), 32'h3FF);
        idle(1);
        chk("idle_mem_en",   32'(mem_en),   32'd0);
        chk("idle_mem_addr", 32'(mem_addr), 32'd0);
        chk("idle_mem_din",  mem_din,       32'd0);

        // Fill addresses 0..7 from port 1 (leaves ptr at port 0).
        for (int i = 0; i < 8; i++)
            cyc("fill", 0, 0, '0, '0, 1, 1, AW'(i), 32'h1000 + i, 0, 1, '0, 1);

        // Contention: both hold reads, grants alternate 0,1,0,1.
        cyc("cont0", 1, 0, 10'h3FF, '0, 1, 0, 10'h001, '0, 1, 0, 32'hDEADBEEF, 1);
        cyc("cont1", 1, 0, 10'h002, '0, 1, 0, 10'h001, '0, 0, 1, 32'h00001001, 1);
        cyc("cont2", 1, 0, 10'h002, '0, 1, 0, 10'h003, '0, 1, 0, 32'h00001002, 1);
        cyc("cont3", 1, 0, 10'h3FF, '0, 1, 0, 10'h003, '0, 0, 1, 32'h00001003, 1);
        cyc("cont4", 1, 0, 10'h3FF, '0, 0, 0, '0, '0, 1, 0, 32'hDEADBEEF, 1);

        // Back-to-back reads from port 1.
        for (int i = 0; i < 8; i++)
            cyc("b2b", 0, 0, '0, '0, 1, 0, AW'(i), '0, 0, 1, 32'h1000 + i, 1);

        // Read-after-write across ports.
        cyc("raw_wr", 1, 1, 10'h005, 32'h12345678, 0, 0, '0, '0, 1, 0, '0, 1);
        cyc("raw_rd", 0, 0, '0, '0, 1, 0, 10'h005, '0, 0, 1, 32'h12345678, 1);

        // With ptr=1, a port-0 write loses to a port-1 read.
        cyc("ptr_set", 1, 0, 10'h000, '0, 0, 0, '0, '0, 1, 0, 32'h00001000, 1);
        cyc("sim_a", 1, 1, 10'h020, 32'hCAFEF00D, 1, 0, 10'h3FF, '0, 0, 1, 32'hDEADBEEF, 1);
        cyc("sim_b", 1, 1, 10'h020, 32'hCAFEF00D, 0, 0, '0, '0, 1, 0, '0, 1);
        cyc("sim_c", 0, 0, '0, '0, 1, 0, 10'h020, '0, 0, 1, 32'hCAFEF00D, 1);

        // Port 1 loses, then withdraws its request: nothing reaches the BRAM.
        cyc("drop_a", 1, 0, 10'h001, '0, 1, 0, 10'h002, '0, 1, 0, 32'h00001001, 1);
        cyc("drop_b", 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, '0, 0);
        chk("drop_mem_en", 32'(mem_en), 32'd0);
        idle(3);
        chk("drain1_queue", 32'(sbq.size()), 32'd0);

        // Preload 0x010, issue a read, then reset while that read is in flight.
        cyc("pre010", 1, 1, 10'h010, 32'hA5A5A5A5, 0, 0, '0, '0, 1, 0, '0, 1);
        cyc("rst_rd", 1, 0, 10'h3FF, '0, 0, 0, '0, '0, 1, 0, '0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        #2;
        chk_reset("midrd");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        wait_clear();

        // After reset, ptr is back to port 0.
        cyc("post_a", 1, 0, 10'h010, '0, 1, 0, 10'h001, '0, 1, 0, POST_010, 1);
        cyc("post_b", 0, 0, '0, '0, 1, 0, 10'h001, '0, 0, 1, POST_001, 1);
        idle(3);
        chk("drain2_queue", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
